// File: rtl/seq_key_lock.sv
// seq_key_lock: an access-sequence lock for a bus window.
// Reads whose address nibbles follow the programmed KEY sequence unlock the block.
// A read of the RELOCK nibble, or IDLE_MAX cycles without an access, locks it again.
// Read data comes from an 8-bit LFSR. The data is inverted while the block is locked.
module seq_key_lock #(
   parameter int                        NIB_W    = 4,
   parameter int                        KEY_LEN  = 8,
   parameter logic [KEY_LEN*NIB_W-1:0]  KEY      = 32'h7E3C_5A19,
   parameter logic [NIB_W-1:0]          RELOCK   = 4'hF,
   parameter int                        DATA_W   = 2,
   parameter logic [7:0]                SEED     = 8'hA5,
   parameter int                        IDLE_MAX = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               acc_stb,
   input  logic                               win_sel,
   input  logic                               rd_nwr,
   input  logic [NIB_W-1:0]                   addr,
   output logic [DATA_W-1:0]                  rd_data,
   output logic                               rd_oe,
   output logic                               unlocked,
   output logic [$clog2(KEY_LEN+1)-1:0]       key_idx
);

   localparam int KW = $clog2(KEY_LEN + 1);
   localparam int IW = $clog2(IDLE_MAX + 1);
   localparam logic [KW-1:0] KEY_LEN_K  = KW'(KEY_LEN);
   localparam logic [IW-1:0] IDLE_MAX_K = IW'(IDLE_MAX);

   typedef enum logic {LOCKED, UNLOCKED} state_t;

   state_t            state, state_nxt;
   logic [KW-1:0]     idx_nxt;
   logic [IW-1:0]     idle_cnt, idle_nxt, idle_inc;
   logic [7:0]        lfsr, lfsr_nxt;
   logic [NIB_W-1:0]  exp_nib;
   logic              qr, qw;

   assign qr       = acc_stb & win_sel & rd_nwr;
   assign qw       = acc_stb & win_sel & ~rd_nwr;
   assign idle_inc = idle_cnt + IW'(1);

   // Select the key element that the next qualified read must match.
   always_comb begin
      exp_nib = '0;
      for (int i = 0; i < KEY_LEN; i++) begin
         if (key_idx == KW'(i))
            exp_nib = KEY[i*NIB_W +: NIB_W];
      end
   end

   // State register: holds the lock state, match progress, idle counter and LFSR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= LOCKED;
         key_idx  <= '0;
         idle_cnt <= '0;
         lfsr     <= SEED;
      end else begin
         state    <= state_nxt;
         key_idx  <= idx_nxt;
         idle_cnt <= idle_nxt;
         lfsr     <= lfsr_nxt;
      end
   end

   // Next-state logic: sequence matching while locked, relock/timeout while unlocked.
   always_comb begin
      state_nxt = state;
      idx_nxt   = key_idx;
      idle_nxt  = idle_cnt;
      lfsr_nxt  = lfsr;
      if (qr)
         lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
         LOCKED: begin
            idle_nxt = '0;
            if (qr) begin
               if (addr == exp_nib) begin
                  idx_nxt = key_idx + KW'(1);
                  if (idx_nxt == KEY_LEN_K)
                     state_nxt = UNLOCKED;
               end else begin
                  idx_nxt = (addr == KEY[NIB_W-1:0]) ? KW'(1) : '0;
               end
            end else if (qw) begin
               idx_nxt = '0;
            end
         end
         UNLOCKED: begin
            if (qr && (addr == RELOCK)) begin
               state_nxt = LOCKED;
               idx_nxt   = '0;
               idle_nxt  = '0;
            end else if (qr || qw) begin
               idle_nxt = '0;
            end else if (idle_inc == IDLE_MAX_K) begin
               state_nxt = LOCKED;
               idx_nxt   = '0;
               idle_nxt  = '0;
            end else begin
               idle_nxt = idle_inc;
            end
         end
         default: begin
            state_nxt = LOCKED;
            idx_nxt   = '0;
            idle_nxt  = '0;
         end
      endcase
   end

   // Output logic: status flag, LFSR-derived read data, and the tristate enable.
   always_comb begin
      unlocked = (state == UNLOCKED);
      rd_data  = (state == UNLOCKED) ? lfsr[DATA_W-1:0] : ~lfsr[DATA_W-1:0];
      rd_oe    = win_sel & rd_nwr;
   end

endmodule

// File: tb/tb_seq_key_lock.sv
// tb_seq_key_lock: a self-checking bench for seq_key_lock with default parameters.
// It combines a vector table, hand-written corner sequences, and random traffic.
// All traffic is compared against a behavioural model of the lock.
module tb_seq_key_lock;

   localparam logic [31:0] KEY_P    = 32'h7E3C_5A19;
   localparam logic [7:0]  SEED_P   = 8'hA5;
   localparam int          KEY_LEN  = 8;
   localparam int          IDLE_MAX = 16;
   localparam logic [3:0]  RELOCK_P = 4'hF;

   logic       clk;
   logic       rst;
   logic       acc_stb;
   logic       win_sel;
   logic       rd_nwr;
   logic [3:0] addr;
   logic [1:0] rd_data;
   logic       rd_oe;
   logic       unlocked;
   logic [3:0] key_idx;

   int n_checks;
   int n_errors;

   // Behavioural model state.
   bit         m_unlocked;
   int         m_idx;
   int         m_idle;
   logic [7:0] m_lfsr;

   typedef struct {
      logic       acc;
      logic       win;
      logic       rd;
      logic [3:0] adr;
      logic       exp_u;
      int         exp_idx;
   } vec_t;

   vec_t vecs[21];

   seq_key_lock dut (
      .clk      (clk),
      .rst      (rst),
      .acc_stb  (acc_stb),
      .win_sel  (win_sel),
      .rd_nwr   (rd_nwr),
      .addr     (addr),
      .rd_data  (rd_data),
      .rd_oe    (rd_oe),
      .unlocked (unlocked),
      .key_idx  (key_idx)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] key_nib(int i);
      logic [31:0] k;
      k = KEY_P;
      return k[i*4 +: 4];
   endfunction

   function automatic logic [7:0] lfsr_step(logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   task automatic model_reset();
      m_unlocked = 0;
      m_idx      = 0;
      m_idle     = 0;
      m_lfsr     = SEED_P;
   endtask

   task automatic model_step(logic acc, logic win, logic rd, logic [3:0] a);
      bit qr, qw;
      qr = acc & win & rd;
      qw = acc & win & ~rd;
      if (qr) m_lfsr = lfsr_step(m_lfsr);
      if (!m_unlocked) begin
         if (qr) begin
            if (a == key_nib(m_idx)) begin
               m_idx++;
               if (m_idx == KEY_LEN) begin
                  m_unlocked = 1;
                  m_idle     = 0;
               end
            end else begin
               m_idx = (a == key_nib(0)) ? 1 : 0;
            end
         end else if (qw) begin
            m_idx = 0;
         end
      end else begin
         if (qr && a == RELOCK_P) begin
            m_unlocked = 0;
            m_idx      = 0;
            m_idle     = 0;
         end else if (qr || qw) begin
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle == IDLE_MAX) begin
               m_unlocked = 0;
               m_idx      = 0;
               m_idle     = 0;
            end
         end
      end
   endtask

   task automatic checkOutput(string name, int actual, int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Drives one cycle and checks the combinational outputs before the edge.
   // After the edge, it checks the registered outputs against the model.
   task automatic applyStimulus(logic acc, logic win, logic rd, logic [3:0] a);
      logic [1:0] exp_data;
      acc_stb = acc;
      win_sel = win;
      rd_nwr  = rd;
      addr    = a;
      #1;
      exp_data = m_unlocked ? m_lfsr[1:0] : ~m_lfsr[1:0];
      checkOutput("rd_oe", int'(rd_oe), int'(win & rd));
      checkOutput("rd_data_pre", int'(rd_data), int'(exp_data));
      @(posedge clk);
      #1;
      model_step(acc, win, rd, a);
      checkOutput("unlocked", int'(unlocked), int'(m_unlocked));
      checkOutput("key_idx", int'(key_idx), m_idx);
   endtask

   task automatic do_reset();
      acc_stb = 0;
      win_sel = 0;
      rd_nwr  = 0;
      addr    = 0;
      rst     = 1;
      #3;
      model_reset();
      checkOutput("reset_unlocked", int'(unlocked), 0);
      checkOutput("reset_key_idx", int'(key_idx), 0);
      checkOutput("reset_rd_data", int'(rd_data), 2);
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic unlock_seq();
      for (int i = 0; i < KEY_LEN; i++)
         applyStimulus(1, 1, 1, key_nib(i));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1;
      acc_stb  = 0;
      win_sel  = 0;
      rd_nwr   = 0;
      addr     = 0;
      model_reset();

      vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 1};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 2};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 3};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 4};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'hC, 1'b0, 5};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 6};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'hE, 1'b0, 7};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'h7, 1'b1, 8};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 8};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 1};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 2};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 3};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 1};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 0};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 0};
      vecs[16] = '{1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 1};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 1};
      vecs[18] = '{1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 0};
      vecs[19] = '{1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 1};
      vecs[20] = '{1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 1};

      // Vector table, starting from reset.
      do_reset();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].acc, vecs[i].win, vecs[i].rd, vecs[i].adr);
         checkOutput($sformatf("tbl%0d_unlocked", i), int'(unlocked), int'(vecs[i].exp_u));
         checkOutput($sformatf("tbl%0d_key_idx", i), int'(key_idx), vecs[i].exp_idx);
      end

      // A single read at address 0 right after reset.
      do_reset();
      applyStimulus(1, 1, 1, 4'h0);
      checkOutput("single_read_rd_data", int'(rd_data), 1);
      checkOutput("single_read_key_idx", int'(key_idx), 0);

      // Idle timeout: the lock falls exactly on the IDLE_MAX-th idle edge.
      do_reset();
      unlock_seq();
      for (int k = 1; k <= IDLE_MAX; k++) begin
         applyStimulus(0, 0, 0, 4'h0);
         checkOutput($sformatf("idle%0d_unlocked", k), int'(unlocked), (k < IDLE_MAX) ? 1 : 0);
      end

      // Periodic reads keep the block unlocked. Reading RELOCK then locks it.
      unlock_seq();
      for (int k = 1; k <= 50; k++) begin
         if (k % 10 == 0) applyStimulus(1, 1, 1, 4'h0);
         else             applyStimulus(0, 1, 1, 4'h3);
         checkOutput("keepalive_unlocked", int'(unlocked), 1);
      end
      applyStimulus(1, 1, 1, RELOCK_P);
      checkOutput("relock_unlocked", int'(unlocked), 0);
      checkOutput("relock_key_idx", int'(key_idx), 0);

      // Asynchronous reset while the sequence is half entered.
      do_reset();
      for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, key_nib(i));
      checkOutput("mid_key_idx", int'(key_idx), 5);
      rst = 1;
      #1;
      checkOutput("async_mid_key_idx", int'(key_idx), 0);
      checkOutput("async_mid_rd_data", int'(rd_data), 2);
      rst = 0;
      model_reset();

      // Asynchronous reset while the block is unlocked.
      unlock_seq();
      checkOutput("pre_async_unlocked", int'(unlocked), 1);
      rst = 1;
      #1;
      checkOutput("async_unl_unlocked", int'(unlocked), 0);
      checkOutput("async_unl_key_idx", int'(key_idx), 0);
      checkOutput("async_unl_rd_data", int'(rd_data), 2);
      rst = 0;
      model_reset();

      // Accesses outside the window leave every register untouched.
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, i[0], key_nib(0));
      checkOutput("outside_key_idx", int'(key_idx), 0);
      checkOutput("outside_rd_data", int'(rd_data), 2);

      // Random traffic, biased toward correct key nibbles, with idle bursts.
      for (int n = 0; n < 2000; n++) begin
         logic       ra, rw, rr;
         logic [3:0] rad;
         if (n % 250 == 249) begin
            for (int j = 0; j < 20; j++) applyStimulus(0, $urandom_range(0, 1), 1, 4'h0);
         end
         ra  = ($urandom_range(0, 1) == 1);
         rw  = ($urandom_range(0, 3) != 0);
         rr  = ($urandom_range(0, 3) != 0);
         if (!m_unlocked && $urandom_range(0, 3) != 0) rad = key_nib(m_idx);
         else                                         rad = 4'($urandom_range(0, 15));
         applyStimulus(ra, rw, rr, rad);
      end

      $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
